// File: rtl/pio_poll_pkg.sv
// ---------------------------------------------------------------------------
// pio_poll_pkg
// Shared types and constants for the PIO polling master: FSM state encoding,
// the full-word Avalon byteenable and the default PIO register addresses.
// ---------------------------------------------------------------------------
package pio_poll_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_REQ  = 2'd1,
    RD_WAIT = 2'd2,
    WR_REQ  = 2'd3
  } poll_state_e;

  localparam logic [3:0]  AVM_BE_ALL       = 4'hF;
  localparam logic [31:0] SW_ADDR_DEFAULT  = 32'h0000_1000;
  localparam logic [31:0] LED_ADDR_DEFAULT = 32'h0000_1010;

endpackage : pio_poll_pkg

// File: rtl/poll_interval_timer.sv
// ---------------------------------------------------------------------------
// poll_interval_timer
// Down-counter that sets the idle gap between polls. load_i reloads it with
// PERIOD-1; while en_i is high it counts down and then holds at zero.
//   clk, reset_n : clock, asynchronous active-low reset (reset loads PERIOD-1)
//   load_i       : reload to PERIOD-1 (has priority over en_i)
//   en_i         : decrement enable
//   zero_o       : counter is at zero
// ---------------------------------------------------------------------------
module poll_interval_timer #(
  parameter int unsigned PERIOD = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic load_i,
  input  logic en_i,
  output logic zero_o
);

  localparam int unsigned CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(PERIOD - 1);

  logic [CNT_W-1:0] cnt_q;

  // NOTE: state registers are written only with non-blocking assignments so
  // every flop samples the values from before the edge, whatever the order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= LOAD_VAL;
    end else if (load_i) begin
      cnt_q <= LOAD_VAL;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule : poll_interval_timer

// File: rtl/pio_poll_master.sv
// ---------------------------------------------------------------------------
// pio_poll_master
// Avalon-MM master that periodically reads an input PIO (switches) and
// writes the captured value to an output PIO (LEDs).
//   clk, reset_n          : clock, asynchronous active-low reset
//   enable                : permits new polls (a started sequence always ends)
//   avm_*                 : Avalon-MM master port; read/write/address/data/
//                           byteenable are all registered outputs
//   last_value            : last captured switch value
//   update_count          : number of completed LED writes (wraps)
//   busy                  : FSM is outside IDLE
// Build option: PIO_POLL_CHANGE_ONLY_EN -- skip the LED write when the value
// just read equals the last value written (after the first write since reset).
// ---------------------------------------------------------------------------
module pio_poll_master
  import pio_poll_pkg::*;
#(
  parameter int unsigned POLL_CYCLES = 50000,
  parameter logic [31:0] SW_ADDR     = SW_ADDR_DEFAULT,
  parameter logic [31:0] LED_ADDR    = LED_ADDR_DEFAULT,
  parameter int unsigned DATA_W      = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  output logic [31:0]       avm_address,
  output logic              avm_read,
  output logic              avm_write,
  output logic [31:0]       avm_writedata,
  output logic [3:0]        avm_byteenable,
  input  logic [31:0]       avm_readdata,
  input  logic              avm_readdatavalid,
  input  logic              avm_waitrequest,
  output logic [DATA_W-1:0] last_value,
  output logic [15:0]       update_count,
  output logic              busy
);

  poll_state_e       state_q, state_d;
  logic [DATA_W-1:0] last_value_q, last_value_d;
  logic [15:0]       update_count_q, update_count_d;
  logic              avm_read_q, avm_read_d;
  logic              avm_write_q, avm_write_d;
  logic [31:0]       avm_address_q, avm_address_d;
  logic [31:0]       avm_writedata_q, avm_writedata_d;
  logic [3:0]        avm_byteenable_q, avm_byteenable_d;
  logic              tmr_load, tmr_en, tmr_zero;
  logic [DATA_W-1:0] rd_value;
  logic              unused_rdata;
`ifdef PIO_POLL_CHANGE_ONLY_EN
  logic              written_q, written_d;
`endif

  assign rd_value     = avm_readdata[DATA_W-1:0];
  assign unused_rdata = ^avm_readdata;

  poll_interval_timer #(
    .PERIOD (POLL_CYCLES)
  ) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .load_i  (tmr_load),
    .en_i    (tmr_en),
    .zero_o  (tmr_zero)
  );

  // NOTE: every signal is given a default before the case statement so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d        = state_q;
    last_value_d   = last_value_q;
    update_count_d = update_count_q;
    tmr_load       = 1'b0;
    tmr_en         = 1'b0;
`ifdef PIO_POLL_CHANGE_ONLY_EN
    written_d      = written_q;
`endif

    case (state_q)
      IDLE: begin
        tmr_en = 1'b1;
        if (tmr_zero && enable) state_d = RD_REQ;
      end
      RD_REQ: begin
        if (!avm_waitrequest) state_d = RD_WAIT;
      end
      RD_WAIT: begin
        if (avm_readdatavalid) begin
          last_value_d = rd_value;
          state_d      = WR_REQ;
`ifdef PIO_POLL_CHANGE_ONLY_EN
          // last_value_q always holds the last written value once a write
          // has happened, because a skipped capture stores an equal value.
          if (written_q && (rd_value == last_value_q)) begin
            state_d  = IDLE;
            tmr_load = 1'b1;
          end
`endif
        end
      end
      WR_REQ: begin
        if (!avm_waitrequest) begin
          update_count_d = update_count_q + 16'd1;
          state_d        = IDLE;
          tmr_load       = 1'b1;
`ifdef PIO_POLL_CHANGE_ONLY_EN
          written_d      = 1'b1;
`endif
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Bus outputs are decoded from the next state so they can be registered
    // yet change on the same edge as the state.
    avm_read_d       = (state_d == RD_REQ);
    avm_write_d      = (state_d == WR_REQ);
    avm_address_d    = '0;
    avm_writedata_d  = '0;
    avm_byteenable_d = '0;
    if (state_d == RD_REQ) begin
      avm_address_d = SW_ADDR;
    end else if (state_d == WR_REQ) begin
      avm_address_d                = LED_ADDR;
      avm_writedata_d[DATA_W-1:0]  = last_value_d;
      avm_byteenable_d             = AVM_BE_ALL;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q          <= IDLE;
      last_value_q     <= '0;
      update_count_q   <= '0;
      avm_read_q       <= 1'b0;
      avm_write_q      <= 1'b0;
      avm_address_q    <= '0;
      avm_writedata_q  <= '0;
      avm_byteenable_q <= '0;
`ifdef PIO_POLL_CHANGE_ONLY_EN
      written_q        <= 1'b0;
`endif
    end else begin
      state_q          <= state_d;
      last_value_q     <= last_value_d;
      update_count_q   <= update_count_d;
      avm_read_q       <= avm_read_d;
      avm_write_q      <= avm_write_d;
      avm_address_q    <= avm_address_d;
      avm_writedata_q  <= avm_writedata_d;
      avm_byteenable_q <= avm_byteenable_d;
`ifdef PIO_POLL_CHANGE_ONLY_EN
      written_q        <= written_d;
`endif
    end
  end

  assign avm_read       = avm_read_q;
  assign avm_write      = avm_write_q;
  assign avm_address    = avm_address_q;
  assign avm_writedata  = avm_writedata_q;
  assign avm_byteenable = avm_byteenable_q;
  assign last_value     = last_value_q;
  assign update_count   = update_count_q;
  assign busy           = (state_q != IDLE);

endmodule : pio_poll_master

// File: tb/tb_pio_poll_master.sv
// ---------------------------------------------------------------------------
// tb_pio_poll_master
// Directed bench for pio_poll_master (POLL_CYCLES=4, DATA_W=8) with a small
// Avalon slave model: configurable waitrequest stretch per transfer and
// readdatavalid one clock after read acceptance.
// ---------------------------------------------------------------------------
module tb_pio_poll_master;

  localparam int unsigned POLL   = 4;
  localparam logic [31:0] SW_A   = 32'h0000_1000;
  localparam logic [31:0] LED_A  = 32'h0000_1010;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic [31:0] avm_address;
  logic        avm_read, avm_write;
  logic [31:0] avm_writedata;
  logic [3:0]  avm_byteenable;
  logic [31:0] avm_readdata;
  logic        avm_readdatavalid, avm_waitrequest;
  logic [7:0]  last_value;
  logic [15:0] update_count;
  logic        busy;

  // slave configuration and observations
  logic [31:0] rd_data_cfg = 32'h0;
  int          rd_wait_cfg = 0;
  int          wr_wait_cfg = 0;
  int          rd_acc = 0, wr_acc = 0, rd_rise = 0, both_hi = 0;
  logic [31:0] wr_addr = '0, wr_data = '0;
  logic [3:0]  wr_be = '0;

  int n_checks = 0;
  int n_errors = 0;

  pio_poll_master #(
    .POLL_CYCLES (POLL),
    .SW_ADDR     (SW_A),
    .LED_ADDR    (LED_A),
    .DATA_W      (8)
  ) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .enable            (enable),
    .avm_address       (avm_address),
    .avm_read          (avm_read),
    .avm_write         (avm_write),
    .avm_writedata     (avm_writedata),
    .avm_byteenable    (avm_byteenable),
    .avm_readdata      (avm_readdata),
    .avm_readdatavalid (avm_readdatavalid),
    .avm_waitrequest   (avm_waitrequest),
    .last_value        (last_value),
    .update_count      (update_count),
    .busy              (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Slave model: acts on the falling edge, away from the DUT's active edge.
  initial begin : slave
    bit in_xfer = 0;
    bit rv_pend = 0;
    bit prev_read = 0;
    int wait_left = 0;
    avm_readdata      = '0;
    avm_readdatavalid = 1'b0;
    avm_waitrequest   = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        in_xfer = 0; rv_pend = 0; prev_read = 0;
        avm_waitrequest = 1'b0; avm_readdatavalid = 1'b0; avm_readdata = '0;
      end else begin
        if (avm_read && avm_write) both_hi++;
        if (avm_read && !prev_read) rd_rise++;
        prev_read = avm_read;
        avm_readdatavalid = rv_pend;
        avm_readdata      = rv_pend ? rd_data_cfg : 32'h0;
        rv_pend = 0;
        if (avm_read || avm_write) begin
          if (!in_xfer) begin
            in_xfer   = 1;
            wait_left = avm_read ? rd_wait_cfg : wr_wait_cfg;
          end
          if (wait_left > 0) begin
            avm_waitrequest = 1'b1;
            wait_left--;
          end else begin
            avm_waitrequest = 1'b0;
            in_xfer = 0;
            if (avm_read) begin
              rd_acc++;
              rv_pend = 1;
            end else begin
              wr_acc++;
              wr_addr = avm_address;
              wr_data = avm_writedata;
              wr_be   = avm_byteenable;
            end
          end
        end else begin
          avm_waitrequest = 1'b0;
        end
      end
    end
  end

  task automatic do_reset();
    reset_n = 1'b0;
    enable  = 1'b0;
    rd_wait_cfg = 0; wr_wait_cfg = 0; rd_data_cfg = '0;
    repeat (2) @(posedge clk);
    rd_acc = 0; wr_acc = 0; rd_rise = 0;
    wr_addr = '0; wr_data = '0; wr_be = '0;
  endtask

  task automatic release_reset();
    @(posedge clk);
    #3 reset_n = 1'b1;
  endtask

  task automatic wait_rd_acc(input string tag, input int target);
    int i;
    for (i = 0; i < 60; i++) begin
      @(negedge clk); #1;
      if (rd_acc >= target) break;
    end
    check(tag, (rd_acc >= target), 1);
  endtask

  task automatic wait_wr_acc(input string tag, input int target);
    int i;
    for (i = 0; i < 60; i++) begin
      @(negedge clk); #1;
      if (wr_acc >= target) break;
    end
    check(tag, (wr_acc >= target), 1);
  endtask

  initial begin : main
    bit stable;
    int snap;
    int i;
    int exp_writes;

    // ---- basic poll and reset state ----
    do_reset();
    check("rst_read",   avm_read, 0);
    check("rst_write",  avm_write, 0);
    check("rst_busy",   busy, 0);
    check("rst_count",  update_count, 0);
    check("rst_value",  last_value, 0);
    check("rst_addr",   avm_address, 0);
    rd_data_cfg = 32'h0000_00A5;
    enable = 1'b1;
    release_reset();
    repeat (3) @(posedge clk);
    #1 check("read_not_before_4", avm_read, 0);
    @(posedge clk);
    #1 check("read_at_4", avm_read, 1);
    check("read_addr", avm_address, SW_A);
    wait_wr_acc("t1_wr_timeout", 1);
    check("t1_wr_addr", wr_addr, LED_A);
    check("t1_wr_data", wr_data, 32'h0000_00A5);
    check("t1_wr_be",   {28'h0, wr_be}, 32'hF);
    @(posedge clk);
    #1 check("t1_count", update_count, 1);
    check("t1_value",     last_value, 8'hA5);
    check("t1_idle_busy", busy, 0);
    check("t1_idle_addr", avm_address, 0);
    check("t1_idle_wd",   avm_writedata, 0);
    check("t1_idle_be",   {28'h0, avm_byteenable}, 0);

    // ---- read stretched by waitrequest; upper readdata bits dropped ----
    do_reset();
    rd_wait_cfg = 3;
    rd_data_cfg = 32'hFFFF_FF3C;
    enable = 1'b1;
    release_reset();
    for (i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (avm_read) break;
    end
    check("t2_read_seen", avm_read, 1);
    stable = 1;
    repeat (3) begin
      @(posedge clk); #1;
      if (!(avm_read && avm_address == SW_A)) stable = 0;
    end
    check("t2_read_stable", stable, 1);
    @(posedge clk);
    #1 check("t2_read_drop", avm_read, 0);
    wait_wr_acc("t2_wr_timeout", 1);
    check("t2_wr_data", wr_data, 32'h0000_003C);
    @(posedge clk);
    #1 check("t2_value", last_value, 8'h3C);

    // ---- two polls with identical data ----
    do_reset();
    rd_data_cfg = 32'h0000_005A;
    enable = 1'b1;
    release_reset();
    wait_rd_acc("t3_rd_timeout", 2);
    enable = 1'b0;
    repeat (15) @(posedge clk);
    #1;
`ifdef PIO_POLL_CHANGE_ONLY_EN
    exp_writes = 1;
`else
    exp_writes = 2;
`endif
    check("t3_reads",  rd_acc, 2);
    check("t3_writes", wr_acc, exp_writes);
    check("t3_count",  update_count, exp_writes);
    check("t3_busy",   busy, 0);

    // ---- enable dropped while waiting for read data ----
    do_reset();
    rd_data_cfg = 32'h0000_0011;
    enable = 1'b1;
    release_reset();
    wait_rd_acc("t4_rd_timeout", 1);
    @(posedge clk);
    #1 enable = 1'b0;
    wait_wr_acc("t4_wr_timeout", 1);
    check("t4_wr_data", wr_data, 32'h0000_0011);
    snap = rd_rise;
    repeat (20) @(posedge clk);
    #1 check("t4_no_new_read", rd_rise, snap);
    check("t4_count", update_count, 1);
    check("t4_busy",  busy, 0);

    // ---- reset asserted while a write is stalled ----
    do_reset();
    rd_data_cfg = 32'h0000_0077;
    enable = 1'b1;
    release_reset();
    wait_wr_acc("t5_wr1_timeout", 1);
    wr_wait_cfg = 1000;
    rd_data_cfg = 32'h0000_0078;
    for (i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (avm_write) break;
    end
    check("t5_write_stalled", avm_write, 1);
    check("t5_count_before", update_count, 1);
    check("t5_wd_before",    avm_writedata, 32'h0000_0078);
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b0;
    #1 check("t5_rst_write", avm_write, 0);
    check("t5_rst_count", update_count, 0);
    check("t5_rst_busy",  busy, 0);
    check("t5_rst_value", last_value, 0);
    check("t5_rst_addr",  avm_address, 0);
    enable = 1'b0;
    repeat (2) @(posedge clk);

    check("no_rd_wr_overlap", both_hi, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_pio_poll_master

// File: doc/pio_poll_master.md
PIO_POLL_MASTER -- requirements
Module: pio_poll_master

Interface
REQ-001 SHALL have parameter POLL_CYCLES, default 50000, meaning clocks from the end of one poll to the start of the next read (minimum 1).
REQ-002 SHALL have parameter SW_ADDR, default 32'h0000_1000, meaning the Avalon byte address of the input-PIO data register.
REQ-003 SHALL have parameter LED_ADDR, default 32'h0000_1010, meaning the Avalon byte address of the output-PIO data register.
REQ-004 SHALL have parameter DATA_W, default 8, meaning the number of significant PIO bits (1..32).
REQ-005 SHALL have port clk, input, 1 bit: clock; reset reset_n, asynchronous, active-low; clock clk.
REQ-006 SHALL have port reset_n, input, 1 bit: asynchronous active-low reset.
REQ-007 SHALL have port enable, input, 1 bit: permits new polls.
REQ-008 SHALL have port avm_address, output, 32 bits: master address.
REQ-009 SHALL have ports avm_read and avm_write, outputs, 1 bit each: transfer requests.
REQ-010 SHALL have port avm_writedata, output, 32 bits, and port avm_byteenable, output, 4 bits.
REQ-011 SHALL have ports avm_readdata, input, 32 bits; avm_readdatavalid, input, 1 bit; and avm_waitrequest, input, 1 bit.
REQ-012 SHALL have ports last_value, output, DATA_W bits: last captured switch value; update_count, output, 16 bits: completed LED writes; and busy, output, 1 bit: high in any state other than IDLE.

Function
REQ-013 SHALL implement the states IDLE, RD_REQ, RD_WAIT and WR_REQ.
REQ-014 IDLE: on entry, SHALL load the down-counter with POLL_CYCLES-1 and decrement it each clock; at 0 with enable=1, SHALL go to RD_REQ; at 0 with enable=0, SHALL hold at 0.
REQ-015 RD_REQ: SHALL drive avm_read=1 and avm_address=SW_ADDR, holding them stable while avm_waitrequest=1; on the first clock with waitrequest=0, SHALL go to RD_WAIT.
REQ-016 RD_WAIT: SHALL deassert avm_read; on avm_readdatavalid=1, SHALL capture avm_readdata[DATA_W-1:0] into last_value and go to WR_REQ. readdatavalid in any other state SHALL be ignored.
REQ-017 WR_REQ: SHALL drive avm_write=1, avm_address=LED_ADDR, avm_writedata=zero-extended last_value and avm_byteenable=4'hF, holding them stable while waitrequest=1; on acceptance, SHALL increment update_count and return to IDLE.
REQ-018 update_count SHALL wrap from 16'hFFFF to 0.
REQ-019 avm_read and avm_write SHALL never be high simultaneously; both SHALL be registered outputs.
REQ-020 Deasserting enable mid-transaction SHALL let the current read/write sequence complete, after which no new read is issued.
REQ-021 When idle, avm_address, avm_writedata and avm_byteenable SHALL be 0.

Reset
REQ-022 Asserting reset_n=0 SHALL immediately (asynchronously) force state IDLE, counter POLL_CYCLES-1, all outputs 0, and the internal written-flag cleared, including mid-transaction.
REQ-023 The first poll after reset SHALL begin POLL_CYCLES clocks after release, given enable=1.

Configuration
REQ-024 With macro PIO_POLL_CHANGE_ONLY_EN defined, after capture the block SHALL skip WR_REQ (returning to IDLE, with update_count unchanged) when the captured value equals the previously written value and at least one write has occurred since reset.
REQ-025 Without PIO_POLL_CHANGE_ONLY_EN, every completed read SHALL be followed by a write.

Structure
REQ-026 Package pio_poll_pkg SHALL hold the state enum type, the Avalon byteenable constant 4'hF and the address defaults.
REQ-027 The interval counter SHALL be a sub-module, poll_interval_timer (load, enable, zero flag); the FSM SHALL be in the top level.

Verification (POLL_CYCLES=4, DATA_W=8)
REQ-028 Release reset with enable=1; slave returns 32'h0000_00A5 one clock after read acceptance -> avm_read rises 4 clocks after release; write to LED_ADDR with writedata 32'h0000_00A5 and byteenable 4'hF; last_value=8'hA5; update_count=1.
REQ-029 waitrequest held high 3 clocks during the read -> avm_read and avm_address stay stable for 4 clocks; avm_read drops the clock after acceptance.
REQ-030 readdata 32'hFFFF_FF3C -> writedata 32'h0000_003C.
REQ-031 Two polls both returning 8'h5A -> with the macro, 1 write and update_count=1; without the macro, 2 writes and update_count=2.
REQ-032 enable dropped in RD_WAIT -> write still completes; no further avm_read for 20 clocks.
REQ-033 reset_n pulsed low during WR_REQ with waitrequest=1 -> avm_write=0 in the same clock; update_count=0; busy=0.
